mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 Parameter MEM_HS, default 1, meaning: 1 = memory states wait for mem_ready; 0 = mem_ready ignored and treated as 1.
REQ-002 Parameter CNT_W, default 32, meaning: width of the retired-instruction counter.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 clk_en  in  1  advance enable; when 0, state and counter hold and all strobes (pc_write, ir_write, reg_write, mem_write, mem_req) are 0.
REQ-006 opcode, funct  in  6 each  fields from the instruction register.
REQ-007 mem_ready  in  1  memory access completes this cycle.
REQ-008 pc_write, branch, branch_ne  out  1 each  PC write, BEQ qualifier, BNE qualifier.
REQ-009 pc_src  out  2  PC source: 00 ALUResult, 01 ALUOut, 10 jump target.
REQ-010 alu_control  out  4  ALU operation, using the shared ALU encodings in cpu.svh.
REQ-011 alu_src_a  out  1  ALU A select: 0 PC, 1 register A.
REQ-012 alu_src_b  out  2  ALU B select: 00 register B, 01 constant 4, 10 SignImm, 11 SignImm<<2.
REQ-013 reg_write, reg_dst, mem_to_reg, ior_d, mem_write, ir_write, mem_req  out  1 each  datapath controls.
REQ-014 illegal  out  1  sticky illegal-instruction flag.
REQ-015 state_o  out  4  current state encoding.
REQ-016 instr_count  out  CNT_W  count of retired instructions.

Function
REQ-017 Supported opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
REQ-018 Supported RTYPE functs: ADD 100000, SUB 100010, AND 100100, OR 100101, SLT 101010, SLL 000000, SRL 000010, SRA 000011.
REQ-019 Any output not named for a state is 0 in that state.
REQ-020 State set: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, ADDIEX=8, ADDIWB=9, BRANCH=10, JUMP=11, TRAP=12.
REQ-021 FETCH: ior_d=0, mem_req=1, alu_src_a=0, alu_src_b=01, ADD, pc_src=00.
 - ir_write=1 and pc_write=1 only in the cycle mem_ready=1; then go to DECODE. Otherwise stay in FETCH.
REQ-022 DECODE: alu_src_a=0, alu_src_b=11, ADD (branch target into ALUOut). Next state by opcode:
 - LW or SW -> MEMADR; RTYPE -> EXEC; ADDI -> ADDIEX; BEQ or BNE -> BRANCH; J -> JUMP.
 - Unsupported opcode, or RTYPE with unsupported funct -> TRAP.
REQ-023 MEMADR: alu_src_a=1, alu_src_b=10, ADD. Next: MEMRD for LW, MEMWR for SW.
REQ-024 MEMRD: ior_d=1, mem_req=1; go to MEMWB on mem_ready, else hold.
REQ-025 MEMWB: reg_dst=0, mem_to_reg=1, reg_write=1; then FETCH.
REQ-026 MEMWR: ior_d=1, mem_req=1, mem_write=1 held every cycle until mem_ready; then FETCH.
REQ-027 EXEC: alu_src_a=1, alu_src_b=00, alu_control decoded from funct; then ALUWB.
REQ-028 ALUWB: reg_dst=1, mem_to_reg=0, reg_write=1; then FETCH.
REQ-029 ADDIEX: alu_src_a=1, alu_src_b=10, ADD; then ADDIWB.
REQ-030 ADDIWB: reg_dst=0, mem_to_reg=0, reg_write=1; then FETCH.
REQ-031 BRANCH: alu_src_a=1, alu_src_b=00, SUB, pc_src=01; branch=1 for BEQ, branch_ne=1 for BNE; then FETCH.
 - The datapath forms PC enable as pc_write | (branch & zero) | (branch_ne & ~zero).
REQ-032 JUMP: pc_src=10, pc_write=1; then FETCH.
REQ-033 TRAP: illegal=1; no strobes; remain in TRAP until rst.
REQ-034 instr_count increments by 1 on each transition into FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH or JUMP.
 - Wraps modulo 2^CNT_W.
 - Not incremented on entry to TRAP.
REQ-035 With MEM_HS=0, FETCH, MEMRD and MEMWR each take exactly one enabled cycle.
 - Resulting latencies: R-type/ADDI 4 cycles, LW 5, SW 4, BEQ/BNE/J 3.

Reset
REQ-036 rst=1 at a clock edge forces state FETCH, illegal=0 and instr_count=0, regardless of clk_en or mem_ready.
REQ-037 Mid-operation reset, including during a memory wait, abandons the instruction and does not increment instr_count.
REQ-038 In the first cycle after reset, FETCH outputs are driven (mem_req=1, ior_d=0).

Verification
REQ-039 MEM_HS=0, ADD then LW then SW -> state_o sequence 0,1,6,7 / 0,1,2,3,4 / 0,1,2,5; instr_count=3.
REQ-040 MEM_HS=1, mem_ready held low 3 cycles during FETCH -> state_o=0, ir_write=0 and pc_write=0 for 3 cycles; on ready, ir_write=pc_write=1 for exactly 1 cycle.
REQ-041 BNE with zero=0 and BEQ with zero=1 -> branch_ne=1 and branch=1 respectively in BRANCH with pc_src=01; 3 cycles each.
REQ-042 opcode 111111 -> TRAP, illegal=1 held for 20 cycles, instr_count unchanged; then rst -> state_o=0, illegal=0.
REQ-043 clk_en=0 for 5 cycles in EXEC -> state held and reg_write=0 throughout; resumes to ALUWB when clk_en=1.
REQ-044 CNT_W=4, 17 retired ADDI instructions -> instr_count=1 (wrap).

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multi-cycle control unit for the MIPS subset: sequences fetch/decode/execute,
// drives datapath selects and strobes, and counts retired instructions.
module mc_control_fsm #(
  parameter int MEM_HS = 1,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_en,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             branch,
  output logic             branch_ne,
  output logic [1:0]       pc_src,
  output logic [3:0]       alu_control,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             reg_write,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             ior_d,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_req,
  output logic             illegal,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;
  localparam logic [3:0] ALU_SRA = 4'b1010;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_ADDIEX = 4'd8,
    S_ADDIWB = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11,
    S_TRAP   = 4'd12
  } state_t;

  state_t     state, state_nx;
  logic       ready;
  logic       retire;
  logic       funct_ok;
  logic [3:0] funct_alu;

  assign ready   = (MEM_HS == 0) ? 1'b1 : mem_ready;
  assign state_o = state;

  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = ALU_ADD;
    case (funct)
      6'b100000: funct_alu = ALU_ADD;
      6'b100010: funct_alu = ALU_SUB;
      6'b100100: funct_alu = ALU_AND;
      6'b100101: funct_alu = ALU_OR;
      6'b101010: funct_alu = ALU_SLT;
      6'b000000: funct_alu = ALU_SLL;
      6'b000010: funct_alu = ALU_SRL;
      6'b000011: funct_alu = ALU_SRA;
      default:   funct_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_nx    = state;
    retire      = 1'b0;
    pc_write    = 1'b0;
    branch      = 1'b0;
    branch_ne   = 1'b0;
    pc_src      = 2'b00;
    alu_control = 4'b0000;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    ior_d       = 1'b0;
    mem_write   = 1'b0;
    ir_write    = 1'b0;
    mem_req     = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        alu_src_b   = 2'b01;
        alu_control = ALU_ADD;
        ir_write    = ready;
        pc_write    = ready;
        if (ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b   = 2'b11;
        alu_control = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:   state_nx = S_MEMADR;
          OP_RTYPE:       state_nx = funct_ok ? S_EXEC : S_TRAP;
          OP_ADDI:        state_nx = S_ADDIEX;
          OP_BEQ, OP_BNE: state_nx = S_BRANCH;
          OP_J:           state_nx = S_JUMP;
          default:        state_nx = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nx    = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        ior_d   = 1'b1;
        mem_req = 1'b1;
        if (ready) state_nx = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire     = 1'b1;
        state_nx   = S_FETCH;
      end
      S_MEMWR: begin
        ior_d     = 1'b1;
        mem_req   = 1'b1;
        mem_write = 1'b1;
        if (ready) begin
          retire   = 1'b1;
          state_nx = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a   = 1'b1;
        alu_control = funct_alu;
        state_nx    = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst   = 1'b1;
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a   = 1'b1;
        alu_src_b   = 2'b10;
        alu_control = ALU_ADD;
        state_nx    = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_nx  = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        pc_src      = 2'b01;
        branch      = (opcode == OP_BEQ);
        branch_ne   = (opcode == OP_BNE);
        retire      = 1'b1;
        state_nx    = S_FETCH;
      end
      S_JUMP: begin
        pc_src   = 2'b10;
        pc_write = 1'b1;
        retire   = 1'b1;
        state_nx = S_FETCH;
      end
      S_TRAP:  illegal  = 1'b1;
      default: state_nx = S_FETCH;
    endcase
    // A stalled cycle must not commit anything to PC, IR, registers or memory.
    if (!clk_en) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_write = 1'b0;
      mem_req   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      instr_count <= '0;
    end else if (clk_en) begin
      state <= state_nx;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: one handshaking instance (MEM_HS=1, 32-bit count) and one
// free-running instance (MEM_HS=0, 4-bit count) checked against an instruction-path model.
module tb_mc_control_fsm;

  localparam logic [5:0] OP_RTYPE = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_BEQ = 6'b000100, OP_BNE = 6'b000101, OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J = 6'b000010, OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100, F_OR = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010, F_SLL = 6'b000000, F_SRL = 6'b000010, F_SRA = 6'b000011;

  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b1, mem_ready = 1'b0;
  logic [5:0] opcode = '0, funct = '0;

  logic hs_pcw, hs_br, hs_bne, hs_asa, hs_rw, hs_rd, hs_m2r, hs_iord, hs_mw, hs_irw, hs_mreq, hs_ill;
  logic nh_pcw, nh_br, nh_bne, nh_asa, nh_rw, nh_rd, nh_m2r, nh_iord, nh_mw, nh_irw, nh_mreq, nh_ill;
  logic [1:0] hs_psrc, nh_psrc, hs_asb, nh_asb;
  logic [3:0] hs_alu, nh_alu, hs_state, nh_state;
  logic [31:0] hs_cnt;
  logic [3:0]  nh_cnt;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_HS(1), .CNT_W(32)) dut_hs (
    .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(hs_pcw), .branch(hs_br), .branch_ne(hs_bne), .pc_src(hs_psrc), .alu_control(hs_alu),
    .alu_src_a(hs_asa), .alu_src_b(hs_asb), .reg_write(hs_rw), .reg_dst(hs_rd), .mem_to_reg(hs_m2r),
    .ior_d(hs_iord), .mem_write(hs_mw), .ir_write(hs_irw), .mem_req(hs_mreq), .illegal(hs_ill),
    .state_o(hs_state), .instr_count(hs_cnt));

  mc_control_fsm #(.MEM_HS(0), .CNT_W(4)) dut_nh (
    .clk(clk), .rst(rst), .clk_en(clk_en), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .pc_write(nh_pcw), .branch(nh_br), .branch_ne(nh_bne), .pc_src(nh_psrc), .alu_control(nh_alu),
    .alu_src_a(nh_asa), .alu_src_b(nh_asb), .reg_write(nh_rw), .reg_dst(nh_rd), .mem_to_reg(nh_m2r),
    .ior_d(nh_iord), .mem_write(nh_mw), .ir_write(nh_irw), .mem_req(nh_mreq), .illegal(nh_ill),
    .state_o(nh_state), .instr_count(nh_cnt));

  // sel picks which instance the model tracks: 1 = handshaking, 0 = no handshake
  bit sel = 1'b1;
  logic [3:0]  o_state;
  logic [19:0] o_ctl;
  logic [31:0] o_cnt;
  always_comb begin
    if (sel) begin
      o_state = hs_state;
      o_cnt   = hs_cnt;
      o_ctl   = {hs_pcw, hs_br, hs_bne, hs_psrc, hs_alu, hs_asa, hs_asb, hs_rw, hs_rd, hs_m2r,
                 hs_iord, hs_mw, hs_irw, hs_mreq, hs_ill};
    end else begin
      o_state = nh_state;
      o_cnt   = {28'd0, nh_cnt};
      o_ctl   = {nh_pcw, nh_br, nh_bne, nh_psrc, nh_alu, nh_asa, nh_asb, nh_rw, nh_rd, nh_m2r,
                 nh_iord, nh_mw, nh_irw, nh_mreq, nh_ill};
    end
  end

  int n_tests = 0, n_fail = 0;

  // Model: each instruction is the list of states it visits; memory steps may stall.
  int          m_path[$];
  int          m_pos;
  logic [31:0] m_cnt;
  logic [5:0]  m_op, m_fn;

  function automatic bit fn_ok(logic [5:0] fn);
    return fn inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_SRA};
  endfunction

  function automatic logic [3:0] alu_of(logic [5:0] fn);
    case (fn)
      F_SUB:   return 4'b0110;
      F_AND:   return 4'b0000;
      F_OR:    return 4'b0001;
      F_SLT:   return 4'b0111;
      F_SLL:   return 4'b1000;
      F_SRL:   return 4'b1001;
      F_SRA:   return 4'b1010;
      default: return 4'b0010;
    endcase
  endfunction

  function automatic logic [19:0] exp_ctl(int st, logic [5:0] op, logic [5:0] fn, bit rdy, bit en);
    logic pcw = 0, br = 0, bne = 0, asa = 0, rw = 0, rd = 0, m2r = 0;
    logic iord = 0, mw = 0, irw = 0, mreq = 0, ill = 0;
    logic [1:0] psrc = 0, asb = 0;
    logic [3:0] alu = 0;
    case (st)
      0:  begin mreq = 1; asb = 2'b01; alu = 4'b0010; irw = rdy; pcw = rdy; end
      1:  begin asb = 2'b11; alu = 4'b0010; end
      2:  begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      3:  begin iord = 1; mreq = 1; end
      4:  begin m2r = 1; rw = 1; end
      5:  begin iord = 1; mreq = 1; mw = 1; end
      6:  begin asa = 1; alu = alu_of(fn); end
      7:  begin rd = 1; rw = 1; end
      8:  begin asa = 1; asb = 2'b10; alu = 4'b0010; end
      9:  rw = 1;
      10: begin asa = 1; alu = 4'b0110; psrc = 2'b01; br = (op == OP_BEQ); bne = (op == OP_BNE); end
      11: begin psrc = 2'b10; pcw = 1; end
      default: ill = 1;
    endcase
    if (!en) begin pcw = 0; irw = 0; rw = 0; mw = 0; mreq = 0; end
    return {pcw, br, bne, psrc, alu, asa, asb, rw, rd, m2r, iord, mw, irw, mreq, ill};
  endfunction

  task automatic new_instr(input logic [5:0] op, input logic [5:0] fn);
    m_op = op; m_fn = fn; opcode = op; funct = fn; m_pos = 0;
    if (op == OP_RTYPE && fn_ok(fn))    m_path = '{0, 1, 6, 7};
    else if (op == OP_LW)               m_path = '{0, 1, 2, 3, 4};
    else if (op == OP_SW)               m_path = '{0, 1, 2, 5};
    else if (op == OP_BEQ || op == OP_BNE) m_path = '{0, 1, 10};
    else if (op == OP_ADDI)             m_path = '{0, 1, 8, 9};
    else if (op == OP_J)                m_path = '{0, 1, 11};
    else                                m_path = '{0, 1, 12};
  endtask

  task automatic cycle(input bit en, input bit rdy);
    int st;
    bit rdy_eff;
    logic [19:0] ev;
    logic [31:0] cmask;
    clk_en = en; mem_ready = rdy;
    #1;
    st = m_path[m_pos];
    rdy_eff = sel ? rdy : 1'b1;
    cmask = sel ? 32'hFFFF_FFFF : 32'h0000_000F;
    ev = exp_ctl(st, m_op, m_fn, rdy_eff, en);
    n_tests++;
    if (o_state !== 4'(st)) begin
      n_fail++; $display("FAIL state: got %0d expected %0d (sel=%0d)", o_state, st, sel);
    end
    n_tests++;
    if (o_ctl !== ev) begin
      n_fail++; $display("FAIL ctl st=%0d en=%0d rdy=%0d: got %b expected %b", st, en, rdy_eff, o_ctl, ev);
    end
    n_tests++;
    if (o_cnt !== (m_cnt & cmask)) begin
      n_fail++; $display("FAIL instr_count: got %0d expected %0d", o_cnt, m_cnt & cmask);
    end
    @(posedge clk); #1;
    if (en && st != 12 && !((st == 0 || st == 3 || st == 5) && !rdy_eff)) begin
      m_pos++;
      if (m_pos == m_path.size()) begin m_pos = 0; m_cnt++; end
    end
  endtask

  task automatic finish_instr(input bit rnd, output int ncyc);
    logic [31:0] c0;
    c0 = m_cnt; ncyc = 0;
    while (m_cnt == c0 && m_path[m_pos] != 12 && ncyc < 200) begin
      cycle(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      ncyc++;
    end
    n_tests++;
    if (ncyc >= 200) begin n_fail++; $display("FAIL timeout: got %0d cycles required < 200", ncyc); end
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input bit rnd, output int ncyc);
    new_instr(op, fn);
    finish_instr(rnd, ncyc);
  endtask

  task automatic do_reset();
    rst = 1'b1; clk_en = 1'($urandom); mem_ready = 1'($urandom);
    @(posedge clk); #1;
    rst = 1'b0;
    m_cnt = '0; m_pos = 0; m_path = '{0};
  endtask

  task automatic test_reset();
    for (int s = 0; s < 2; s++) begin
      sel = bit'(s);
      do_reset();
      clk_en = 1'b1; mem_ready = 1'b0;
      #1;
      n_tests++;
      if (o_state !== 4'd0 || o_cnt !== 32'd0 || o_ctl[0] !== 1'b0) begin
        n_fail++; $display("FAIL reset: got state=%0d cnt=%0d ill=%b required 0/0/0", o_state, o_cnt, o_ctl[0]);
      end
      n_tests++;
      if (o_ctl[1] !== 1'b1 || o_ctl[4] !== 1'b0) begin
        n_fail++; $display("FAIL reset_fetch: got mem_req=%b ior_d=%b required 1/0", o_ctl[1], o_ctl[4]);
      end
    end
  endtask

  task automatic test_seq_nohs();
    int n;
    int exp_n[3] = '{4, 5, 4};
    logic [5:0] ops[3] = '{OP_RTYPE, OP_LW, OP_SW};
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      run_instr(ops[i], F_ADD, 1'b0, n);
      n_tests++;
      if (n !== exp_n[i]) begin n_fail++; $display("FAIL latency op=%b: got %0d required %0d", ops[i], n, exp_n[i]); end
    end
    clk_en = 1'b1; #1;
    n_tests++;
    if (nh_cnt !== 4'd3) begin n_fail++; $display("FAIL seq_count: got %0d required 3", nh_cnt); end
  endtask

  task automatic test_fetch_wait();
    int n;
    sel = 1'b1;
    do_reset();
    new_instr(OP_RTYPE, F_OR);
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0);
    clk_en = 1'b1; mem_ready = 1'b1; #1;
    n_tests++;
    if (hs_state !== 4'd0 || hs_irw !== 1'b1 || hs_pcw !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ready: got st=%0d ir=%b pc=%b required 0/1/1", hs_state, hs_irw, hs_pcw);
    end
    cycle(1'b1, 1'b1);
    mem_ready = 1'b1; #1;
    n_tests++;
    if (hs_state !== 4'd1 || hs_irw !== 1'b0 || hs_pcw !== 1'b0) begin
      n_fail++; $display("FAIL fetch_once: got st=%0d ir=%b pc=%b required 1/0/0", hs_state, hs_irw, hs_pcw);
    end
    finish_instr(1'b0, n);
  endtask

  task automatic test_branch();
    logic [5:0] ops[2] = '{OP_BNE, OP_BEQ};
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      new_instr(ops[i], 6'($urandom));
      cycle(1'b1, 1'b1);
      cycle(1'b1, 1'b1);
      clk_en = 1'b1; #1;
      n_tests++;
      if (hs_state !== 4'd10 || hs_psrc !== 2'b01 || hs_bne !== (i == 0) || hs_br !== (i == 1)) begin
        n_fail++; $display("FAIL branch op=%b: got st=%0d psrc=%b br=%b bne=%b", ops[i], hs_state, hs_psrc, hs_br, hs_bne);
      end
      cycle(1'b1, 1'b1);
      n_tests++;
      if (hs_cnt !== 32'(i + 1) || hs_state !== 4'd0) begin
        n_fail++; $display("FAIL branch_3cyc: got cnt=%0d st=%0d required %0d/0", hs_cnt, hs_state, i + 1);
      end
    end
  endtask

  task automatic test_trap();
    int n;
    sel = 1'b1;
    do_reset();
    run_instr(OP_ADDI, 6'($urandom), 1'b1, n);
    run_instr(OP_BAD, F_ADD, 1'b1, n);
    for (int i = 0; i < 20; i++) begin
      cycle(1'($urandom), 1'($urandom));
      n_tests++;
      if (hs_ill !== 1'b1 || hs_cnt !== 32'd1) begin
        n_fail++; $display("FAIL trap_hold: got ill=%b cnt=%0d required 1/1", hs_ill, hs_cnt);
      end
    end
    do_reset();
    #1;
    n_tests++;
    if (hs_state !== 4'd0 || hs_ill !== 1'b0) begin
      n_fail++; $display("FAIL trap_reset: got st=%0d ill=%b required 0/0", hs_state, hs_ill);
    end
    run_instr(OP_RTYPE, 6'b111111, 1'b0, n);
    cycle(1'b1, 1'b1);
  endtask

  task automatic test_clk_en();
    int n;
    sel = 1'b1;
    do_reset();
    new_instr(OP_RTYPE, F_SLT);
    cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      clk_en = 1'b0; #1;
      n_tests++;
      if (hs_state !== 4'd6 || hs_rw !== 1'b0) begin
        n_fail++; $display("FAIL stall: got st=%0d reg_write=%b required 6/0", hs_state, hs_rw);
      end
      cycle(1'b0, 1'($urandom));
    end
    cycle(1'b1, 1'b1);
    n_tests++;
    if (hs_state !== 4'd7) begin n_fail++; $display("FAIL resume: got st=%0d required 7", hs_state); end
    finish_instr(1'b0, n);
  endtask

  task automatic test_mid_reset();
    int n;
    sel = 1'b1;
    do_reset();
    run_instr(OP_J, 6'($urandom), 1'b0, n);
    new_instr(OP_LW, 6'($urandom));
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    do_reset();
    clk_en = 1'b1; mem_ready = 1'b0; #1;
    n_tests++;
    if (hs_state !== 4'd0 || hs_cnt !== 32'd0 || hs_mreq !== 1'b1 || hs_iord !== 1'b0) begin
      n_fail++; $display("FAIL mid_reset: got st=%0d cnt=%0d mreq=%b iord=%b required 0/0/1/0",
                         hs_state, hs_cnt, hs_mreq, hs_iord);
    end
  endtask

  task automatic test_wrap();
    int n;
    sel = 1'b0;
    do_reset();
    for (int i = 0; i < 17; i++) run_instr(OP_ADDI, 6'($urandom), 1'b0, n);
    #1;
    n_tests++;
    if (nh_cnt !== 4'd1) begin n_fail++; $display("FAIL wrap: got %0d required 1", nh_cnt); end
  endtask

  task automatic test_random();
    int n;
    logic [5:0] ops[7] = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    logic [5:0] fns[8] = '{F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_SLL, F_SRL, F_SRA};
    for (int r = 0; r < 4; r++) begin
      sel = bit'(r % 2);
      do_reset();
      for (int i = 0; i < 40; i++)
        run_instr(ops[$urandom_range(0, 6)], fns[$urandom_range(0, 7)], 1'b1, n);
      run_instr(OP_BAD, 6'($urandom), 1'b1, n);
      for (int i = 0; i < 4; i++) cycle(1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_seq_nohs();
    test_fetch_wait();
    test_branch();
    test_trap();
    test_clk_en();
    test_mid_reset();
    test_wrap();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
